// File: rtl/plic_mmio_arbiter_pkg.sv
// Shared types and constants for the PLIC MMIO arbiter slice.
package plic_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        RESP
    } arb_state_e;

    localparam int unsigned PLIC_WINDOW_SHIFT = 24;
    localparam logic [63:0] PLIC_BASE_ADDR    = 64'h0000_0000_0C00_0000;
    localparam int unsigned PLIC_BE_WIDTH     = 8;

endpackage

// File: rtl/plic_mmio_arbiter_if.sv
// Downstream MMIO bus between the arbiter (master) and the PLIC (slave).
interface plic_mmio_if
    import plic_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 64,
    parameter int unsigned DATA_WIDTH = 64
);
    logic [ADDR_WIDTH-1:0]    mmio_addr;
    logic [DATA_WIDTH-1:0]    mmio_write_data;
    logic [PLIC_BE_WIDTH-1:0] mmio_byte_en;
    logic                     mmio_read;
    logic                     mmio_write;
    logic [DATA_WIDTH-1:0]    mmio_read_data;
    logic                     mmio_ready;
    logic                     mmio_error;

    modport master (
        output mmio_addr, mmio_write_data, mmio_byte_en, mmio_read, mmio_write,
        input  mmio_read_data, mmio_ready, mmio_error
    );

    modport slave (
        input  mmio_addr, mmio_write_data, mmio_byte_en, mmio_read, mmio_write,
        output mmio_read_data, mmio_ready, mmio_error
    );
endinterface

// File: rtl/plic_mmio_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first set request above ptr, wrapping.
module rr_arbiter #(
    parameter  int unsigned NUM_REQ = 4,
    localparam int unsigned IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               any_req
);
    logic             found;
    logic [IDX_W-1:0] idx;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = '0;
        any_req   = |req;
        for (int unsigned off = 1; off <= NUM_REQ; off++) begin
            idx = IDX_W'((32'(ptr) + off) % NUM_REQ);
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = idx;
            end
        end
    end
endmodule

// File: rtl/plic_mmio_arbiter.sv
// Round-robin sharing of the PLIC MMIO slave port, one transaction in flight,
// with local window decode and a bounded wait on the slave.
module plic_mmio_arbiter
    import plic_pkg::*;
#(
    parameter int unsigned           NUM_REQ        = 4,
    parameter int unsigned           ADDR_WIDTH     = 64,
    parameter int unsigned           DATA_WIDTH     = 64,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR      = ADDR_WIDTH'(PLIC_BASE_ADDR),
    parameter int unsigned           TIMEOUT_CYCLES = 16
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_REQ-1:0]               req_valid,
    input  logic [NUM_REQ-1:0]               req_write,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_wdata,
    input  logic [NUM_REQ*PLIC_BE_WIDTH-1:0] req_byte_en,
    output logic [NUM_REQ-1:0]               req_ready,
    output logic [NUM_REQ-1:0]               rsp_valid,
    output logic [DATA_WIDTH-1:0]            rsp_rdata,
    output logic                             rsp_error,
    plic_mmio_if.master                      mmio
);
    localparam int unsigned IDX_W = $clog2(NUM_REQ);
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    arb_state_e               state_q, state_d;
    logic [IDX_W-1:0]         ptr_q, ptr_d, gidx_q, gidx_d;
    logic                     wr_q, wr_d, err_q, err_d;
    logic [ADDR_WIDTH-1:0]    addr_q, addr_d;
    logic [DATA_WIDTH-1:0]    wdata_q, wdata_d, rdata_q, rdata_d;
    logic [PLIC_BE_WIDTH-1:0] be_q, be_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;

    logic [NUM_REQ-1:0]       grant;
    logic [IDX_W-1:0]         grant_idx;
    logic                     any_req;

    logic [ADDR_WIDTH-1:0]    addr_arr  [NUM_REQ];
    logic [DATA_WIDTH-1:0]    wdata_arr [NUM_REQ];
    logic [PLIC_BE_WIDTH-1:0] be_arr    [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign addr_arr[i]  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        assign wdata_arr[i] = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
        assign be_arr[i]    = req_byte_en[i*PLIC_BE_WIDTH +: PLIC_BE_WIDTH];
    end

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .req       (req_valid),
        .ptr       (ptr_q),
        .grant     (grant),
        .grant_idx (grant_idx),
        .any_req   (any_req)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= IDX_W'(NUM_REQ - 1);
            gidx_q  <= '0;
            wr_q    <= 1'b0;
            err_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            be_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gidx_q  <= gidx_d;
            wr_q    <= wr_d;
            err_q   <= err_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            be_q    <= be_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        gidx_d    = gidx_q;
        wr_d      = wr_q;
        err_d     = err_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        be_d      = be_q;
        cnt_d     = cnt_q;
        req_ready = '0;
        rsp_valid = '0;
        unique case (state_q)
            IDLE: begin
                if (any_req) begin
                    req_ready = grant;
                    gidx_d    = grant_idx;
                    wr_d      = req_write[grant_idx];
                    addr_d    = addr_arr[grant_idx];
                    wdata_d   = wdata_arr[grant_idx];
                    be_d      = be_arr[grant_idx];
                    if (addr_arr[grant_idx][ADDR_WIDTH-1:PLIC_WINDOW_SHIFT] ==
                        BASE_ADDR[ADDR_WIDTH-1:PLIC_WINDOW_SHIFT]) begin
                        state_d = ISSUE;
                    end else begin
                        // Outside the window: answer locally, never touch the slave
                        state_d = RESP;
                        err_d   = 1'b1;
                        rdata_d = '0;
                    end
                end
            end
            ISSUE: begin
                if (mmio.mmio_ready) begin
                    rdata_d = wr_q ? '0 : mmio.mmio_read_data;
                    err_d   = mmio.mmio_error;
                    state_d = RESP;
                end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RESP: begin
                rsp_valid[gidx_q] = 1'b1;
                ptr_d             = gidx_q;
                cnt_d             = '0;
                state_d           = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign mmio.mmio_addr       = addr_q;
    assign mmio.mmio_write_data = wdata_q;
    assign mmio.mmio_byte_en    = be_q;
    assign mmio.mmio_read       = (state_q == ISSUE) && !wr_q;
    assign mmio.mmio_write      = (state_q == ISSUE) && wr_q;
    assign rsp_rdata            = rdata_q;
    assign rsp_error            = err_q;
endmodule

// File: tb/tb_plic_mmio_arbiter.sv
// Self-checking bench for plic_mmio_arbiter: vector table plus scoreboard of
// expected responses, with a configurable wait-state PLIC model.
module tb_plic_mmio_arbiter;

    typedef struct {
        string       name;
        logic [1:0]  idx;
        bit          write;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [7:0]  be;
        int unsigned plic_wait;
        bit          plic_stuck;
        logic [63:0] plic_rdata;
        bit          plic_err;
        logic [63:0] exp_rdata;
        bit          exp_err;
        int          exp_lat;
        int          exp_strobes;
    } vec_t;

    typedef struct {
        logic [1:0]  idx;
        bit          write;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [7:0]  be;
        logic [63:0] rdata;
        bit          err;
        int          lat;
        int          strobes;
    } sb_t;

    logic         clk;
    logic         rst;
    logic [3:0]   req_valid, req_write, req_ready, rsp_valid;
    logic [255:0] req_addr, req_wdata;
    logic [31:0]  req_byte_en;
    logic [63:0]  rsp_rdata;
    logic         rsp_error;

    logic [3:0]   r_valid, r_write;
    logic [63:0]  r_addr  [4];
    logic [63:0]  r_wdata [4];
    logic [7:0]   r_be    [4];

    int unsigned  plic_wait, plic_cnt;
    bit           plic_stuck, plic_err;
    logic [63:0]  plic_rdata;
    logic         strobe;

    sb_t          sb [$];
    sb_t          e;
    vec_t         vecs [$];
    int           cyc, last_accept, rd_cnt, wr_cnt;
    int           n_tests, n_fail;
    bit           ok;

    plic_mmio_if #(.ADDR_WIDTH(64), .DATA_WIDTH(64)) mmio_if ();

    plic_mmio_arbiter #(
        .NUM_REQ        (4),
        .ADDR_WIDTH     (64),
        .DATA_WIDTH     (64),
        .BASE_ADDR      (64'h0000_0000_0C00_0000),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_write   (req_write),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .req_byte_en (req_byte_en),
        .req_ready   (req_ready),
        .rsp_valid   (rsp_valid),
        .rsp_rdata   (rsp_rdata),
        .rsp_error   (rsp_error),
        .mmio        (mmio_if)
    );

    for (genvar gi = 0; gi < 4; gi++) begin : g_pack
        assign req_addr[gi*64 +: 64]  = r_addr[gi];
        assign req_wdata[gi*64 +: 64] = r_wdata[gi];
        assign req_byte_en[gi*8 +: 8] = r_be[gi];
    end
    assign req_valid = r_valid;
    assign req_write = r_write;

    // PLIC model: asserts ready after plic_wait stalled strobe cycles
    assign strobe = mmio_if.mmio_read | mmio_if.mmio_write;
    always_comb begin
        mmio_if.mmio_ready     = strobe && !plic_stuck && (plic_cnt == plic_wait);
        mmio_if.mmio_read_data = plic_rdata;
        mmio_if.mmio_error     = plic_err;
    end
    always @(posedge clk) plic_cnt <= (strobe && !mmio_if.mmio_ready) ? plic_cnt + 1 : 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end
    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (mmio_if.mmio_read)  rd_cnt++;
            if (mmio_if.mmio_write) wr_cnt++;
            if (strobe && sb.size() > 0) chk("mmio_addr", mmio_if.mmio_addr, sb[0].addr);
            if (mmio_if.mmio_write && sb.size() > 0) begin
                chk("mmio_wdata", mmio_if.mmio_write_data, sb[0].wdata);
                chk("mmio_be", 64'(mmio_if.mmio_byte_en), 64'(sb[0].be));
            end
            if (rsp_valid != 4'b0) begin
                if (sb.size() == 0) begin
                    chk("unexpected_rsp", 64'(rsp_valid), 64'd0);
                end else begin
                    e = sb.pop_front();
                    chk("rsp_valid", 64'(rsp_valid), 64'(4'b1 << e.idx));
                    chk("rsp_rdata", rsp_rdata, e.rdata);
                    chk("rsp_error", 64'(rsp_error), 64'(e.err));
                    chk("latency", 64'(cyc - last_accept), 64'(e.lat));
                    chk("read_strobes", 64'(rd_cnt), 64'(e.write ? 0 : e.strobes));
                    chk("write_strobes", 64'(wr_cnt), 64'(e.write ? e.strobes : 0));
                end
                rd_cnt = 0;
                wr_cnt = 0;
            end
        end
    end

    task automatic wait_ready(output bit found);
        found = 1'b0;
        for (int t = 0; t < 64; t++) begin
            #1;
            if (|req_ready) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic wait_drain(input string name);
        for (int t = 0; t < 64; t++) begin
            if (sb.size() == 0) break;
            @(negedge clk);
            #1;
        end
        if (sb.size() != 0) begin
            chk({name, "_rsp_timeout"}, 64'(sb.size()), 64'd0);
            sb.delete();
        end
    endtask

    task automatic check_idle_outputs(input string name);
        chk({name, "_req_ready"}, 64'(req_ready), 64'd0);
        chk({name, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
        chk({name, "_rsp_rdata"}, rsp_rdata, 64'd0);
        chk({name, "_rsp_error"}, 64'(rsp_error), 64'd0);
        chk({name, "_strobes"}, 64'({mmio_if.mmio_read, mmio_if.mmio_write}), 64'd0);
        chk({name, "_mmio_addr"}, mmio_if.mmio_addr, 64'd0);
        chk({name, "_mmio_wdata"}, mmio_if.mmio_write_data, 64'd0);
        chk({name, "_mmio_be"}, 64'(mmio_if.mmio_byte_en), 64'd0);
    endtask

    task automatic run_vector(input vec_t v);
        sb_t x;
        bit  got;
        @(negedge clk);
        plic_wait  = v.plic_wait;
        plic_stuck = v.plic_stuck;
        plic_rdata = v.plic_rdata;
        plic_err   = v.plic_err;
        x = '{idx: v.idx, write: v.write, addr: v.addr, wdata: v.wdata, be: v.be,
              rdata: v.exp_rdata, err: v.exp_err, lat: v.exp_lat, strobes: v.exp_strobes};
        sb.push_back(x);
        r_valid[v.idx] = 1'b1;
        r_write[v.idx] = v.write;
        r_addr[v.idx]  = v.addr;
        r_wdata[v.idx] = v.wdata;
        r_be[v.idx]    = v.be;
        wait_ready(got);
        if (!got) begin
            chk({v.name, "_accept_timeout"}, 64'd0, 64'd1);
            sb.delete();
            r_valid = '0;
            return;
        end
        chk({v.name, "_req_ready"}, 64'(req_ready), 64'(4'b1 << v.idx));
        last_accept = cyc;
        @(posedge clk);
        #1;
        r_valid[v.idx] = 1'b0;
        wait_drain(v.name);
    endtask

    // Requesters in mask hold valid continuously; grants must follow ord
    task automatic run_multi(input logic [3:0] mask, input int n,
                             input logic [1:0] ord [5], input string name);
        sb_t x;
        bit  got;
        @(negedge clk);
        plic_wait  = 0;
        plic_stuck = 1'b0;
        plic_err   = 1'b0;
        foreach (r_addr[i]) r_addr[i] = 64'h0C00_2000 + 64'(i) * 4;
        r_write = '0;
        r_valid = mask;
        for (int k = 0; k < n; k++) begin
            wait_ready(got);
            if (!got) begin
                chk({name, "_accept_timeout"}, 64'd0, 64'd1);
                break;
            end
            chk({name, "_grant"}, 64'(req_ready), 64'(4'b1 << ord[k]));
            plic_rdata = 64'h100 + 64'(k);
            x = '{idx: ord[k], write: 1'b0, addr: 64'h0C00_2000 + 64'(ord[k]) * 4,
                  wdata: 64'd0, be: 8'd0, rdata: 64'h100 + 64'(k), err: 1'b0, lat: 2, strobes: 1};
            sb.push_back(x);
            last_accept = cyc;
            @(posedge clk);
            if (k == n - 1) begin
                #1;
                r_valid = '0;
            end
        end
        r_valid = '0;
        wait_drain(name);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got hang, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        n_tests = 0; n_fail = 0; cyc = 0; last_accept = 0; rd_cnt = 0; wr_cnt = 0;
        rst = 1'b1; r_valid = '0; r_write = '0;
        foreach (r_addr[i]) begin
            r_addr[i] = '0; r_wdata[i] = '0; r_be[i] = '0;
        end
        plic_wait = 0; plic_stuck = 1'b0; plic_err = 1'b0; plic_rdata = '0;

        //            name        idx  wr    addr                    wdata                    be     wait stk plic_rdata               perr exp_rdata                eerr lat str
        vecs.push_back('{"single_rd", 2'd1, 1'b0, 64'h0000_0000_0C20_0004, 64'd0,                  8'h00, 0,  0, 64'h5,                   0,  64'h5,                   0,  2,  1});
        vecs.push_back('{"write",     2'd2, 1'b1, 64'h0000_0000_0C00_0008, 64'hDEAD_BEEF_0000_0007, 8'h0F, 0,  0, 64'hFFFF,                0,  64'd0,                   0,  2,  1});
        vecs.push_back('{"oow_rd",    2'd3, 1'b0, 64'h0000_0000_1000_0000, 64'd0,                  8'h00, 0,  0, 64'h99,                  0,  64'd0,                   1,  1,  0});
        vecs.push_back('{"wait3",     2'd0, 1'b0, 64'h0000_0000_0C00_1000, 64'd0,                  8'h00, 3,  0, 64'h1234_5678_9ABC_DEF0, 0,  64'h1234_5678_9ABC_DEF0, 0,  5,  4});
        vecs.push_back('{"timeout",   2'd2, 1'b0, 64'h0000_0000_0C20_0000, 64'd0,                  8'h00, 0,  1, 64'h77,                  0,  64'd0,                   1,  17, 16});
        vecs.push_back('{"after_to",  2'd2, 1'b0, 64'h0000_0000_0C20_0000, 64'd0,                  8'h00, 0,  0, 64'hA5,                  0,  64'hA5,                  0,  2,  1});
        vecs.push_back('{"slv_err",   2'd1, 1'b0, 64'h0000_0000_0C00_0004, 64'd0,                  8'h00, 0,  0, 64'h77,                  1,  64'h77,                  1,  2,  1});
        vecs.push_back('{"below_win", 2'd3, 1'b1, 64'h0000_0000_0BFF_FFFC, 64'h1111,               8'hFF, 0,  0, 64'h0,                   0,  64'd0,                   1,  1,  0});
        vecs.push_back('{"top_win",   2'd0, 1'b1, 64'h0000_0000_0CFF_FFF8, 64'h2222_3333,          8'hF0, 1,  0, 64'h55,                  0,  64'd0,                   0,  3,  2});
        vecs.push_back('{"hi_bits",   2'd0, 1'b0, 64'h0000_0001_0C00_0010, 64'd0,                  8'h00, 0,  0, 64'h66,                  0,  64'd0,                   1,  1,  0});
        vecs.push_back('{"last_r0",   2'd0, 1'b0, 64'h0000_0000_0C00_0020, 64'd0,                  8'h00, 0,  0, 64'h42,                  0,  64'h42,                  0,  2,  1});

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_idle_outputs("reset");

        run_multi(4'b1111, 5, '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0}, "contention");

        do_reset();
        foreach (vecs[i]) run_vector(vecs[i]);

        // Abandon a stalled read by reset; requester 0 must win next despite ptr=0 before
        @(negedge clk);
        plic_stuck = 1'b1;
        plic_wait  = 0;
        r_valid[1] = 1'b1;
        r_write[1] = 1'b0;
        r_addr[1]  = 64'h0C00_0100;
        wait_ready(ok);
        chk("rstmid_accept", 64'(req_ready), 64'b0010);
        @(posedge clk);
        #1;
        r_valid[1] = 1'b0;
        repeat (3) @(negedge clk);
        chk("rstmid_strobe_before", 64'(mmio_if.mmio_read), 64'd1);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_idle_outputs("rstmid");
        repeat (3) begin
            @(negedge clk);
            chk("rstmid_no_strobe", 64'({mmio_if.mmio_read, mmio_if.mmio_write}), 64'd0);
        end
        rd_cnt = 0;
        wr_cnt = 0;
        plic_stuck = 1'b0;
        run_multi(4'b1001, 2, '{2'd0, 2'd3, 2'd0, 2'd0, 2'd0}, "post_rst");

        repeat (4) @(negedge clk);
        chk("sb_empty", 64'(sb.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
